// File: rtl/pipe_hazard_scoreboard.sv
// Unified hazard unit beside ID: tracks in-flight destinations, chooses stall or
// forwarding per operand, and handles branches by stall-until-resolve or flush.
module pipe_hazard_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 3,
  parameter int FWD_EN    = 1,
  parameter int LOAD_LAT  = 2,
  parameter int CTRL_MODE = 0,
  parameter int BR_STAGE  = 2,
  parameter int FSEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_is_ctrl,
  input  logic              redirect,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [FSEL_W-1:0] fwd_sel_rs,
  output logic [FSEL_W-1:0] fwd_sel_rt
);

  localparam int CNT_W = $clog2(BR_STAGE + 2);

  typedef enum logic {IDLE, CWAIT} stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              ctrlBusy;

  logic [DEPTH-1:0]  sbV, sbLoad, sbCtrl;
  logic [REG_AW-1:0] sbDest [DEPTH];

  logic              rsHit, rsLd, rsEarly, rtHit, rtLd, rtEarly;
  logic [FSEL_W-1:0] rsSel, rtSel;
  logic              rawStall, redirectFlush, stallInt, bubbleInt;

  // Scan oldest to youngest so the youngest matching producer is the one kept.
  always_comb begin
    rsHit = 1'b0; rsLd = 1'b0; rsEarly = 1'b0; rsSel = '0;
    rtHit = 1'b0; rtLd = 1'b0; rtEarly = 1'b0; rtSel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (id_use_rs && (id_rs != '0) && sbV[k] && (sbDest[k] == id_rs)) begin
        rsHit   = 1'b1;
        rsLd    = sbLoad[k];
        rsEarly = (k + 1 < LOAD_LAT);
        rsSel   = FSEL_W'(k + 1);
      end
      if (id_use_rt && (id_rt != '0) && sbV[k] && (sbDest[k] == id_rt)) begin
        rtHit   = 1'b1;
        rtLd    = sbLoad[k];
        rtEarly = (k + 1 < LOAD_LAT);
        rtSel   = FSEL_W'(k + 1);
      end
    end
  end

  always_comb begin
    rawStall = 1'b0;
    if (id_valid) begin
      if (FWD_EN == 0) rawStall = rsHit | rtHit;
      else             rawStall = (rsHit & rsLd & rsEarly) | (rtHit & rtLd & rtEarly);
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    ctrlBusy  = 1'b0;
    case (state)
      IDLE: begin
        if ((CTRL_MODE == 0) && id_valid && id_is_ctrl && !rawStall) begin
          stateNext = CWAIT;
          cntNext   = CNT_W'(BR_STAGE + 1);
        end
      end
      CWAIT: begin
        ctrlBusy = 1'b1;
        cntNext  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) stateNext = IDLE;
      end
    endcase
  end

  assign redirectFlush = (CTRL_MODE == 1) && redirect && sbCtrl[BR_STAGE];
  assign stallInt      = rawStall | ctrlBusy;
  assign bubbleInt     = stallInt | redirectFlush;

  // Reset must silence the control outputs immediately, even mid-stall.
  assign stall  = rst_n & stallInt;
  assign bubble = rst_n & bubbleInt;
  assign flush  = rst_n & redirectFlush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Wrong-path instructions younger than the branch die as they shift onward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sbV    <= '0;
      sbLoad <= '0;
      sbCtrl <= '0;
      for (int k = 0; k < DEPTH; k++) sbDest[k] <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sbV[k]    <= sbV[k-1];
        sbDest[k] <= sbDest[k-1];
        sbLoad[k] <= sbLoad[k-1];
        sbCtrl[k] <= sbCtrl[k-1];
        if (redirectFlush && (k <= BR_STAGE)) begin
          sbV[k]    <= 1'b0;
          sbCtrl[k] <= 1'b0;
        end
      end
      if (bubbleInt) begin
        sbV[0]    <= 1'b0;
        sbDest[0] <= '0;
        sbLoad[0] <= 1'b0;
        sbCtrl[0] <= 1'b0;
      end else begin
        sbV[0]    <= id_valid & id_reg_write & (id_dest != '0);
        sbDest[0] <= id_dest;
        sbLoad[0] <= id_is_load;
        sbCtrl[0] <= id_valid & id_is_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bubbleInt) begin
      fwd_sel_rs <= '0;
      fwd_sel_rt <= '0;
    end else begin
      fwd_sel_rs <= (FWD_EN != 0) ? rsSel : '0;
      fwd_sel_rt <= (FWD_EN != 0) ? rtSel : '0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Scoreboard bench for pipe_hazard_scoreboard: a forwarding/stall-branch instance
// and a no-forwarding/flush instance, each stepped cycle by cycle.
module tb_pipe_hazard_scoreboard;

  typedef struct packed {
    logic       rstN;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRs;
    logic       useRt;
    logic [4:0] dest;
    logic       regWrite;
    logic       isLoad;
    logic       isCtrl;
    logic       redirect;
  } stimT;

  typedef struct {
    string      name;
    int         which;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [1:0] selRs;
    logic [1:0] selRt;
  } expT;

  logic       clk;
  logic       rstN;
  stimT       in0, in1;
  logic       stall0, bubble0, flush0, stall1, bubble1, flush1;
  logic [1:0] selRs0, selRt0, selRs1, selRt1;

  expT combQ[$];
  expT selQ[$];
  int  errCount   = 0;
  int  checkCount = 0;

  pipe_hazard_scoreboard #(
    .REG_AW(5), .DEPTH(3), .FWD_EN(1), .LOAD_LAT(2), .CTRL_MODE(0), .BR_STAGE(2)
  ) dutFwd (
    .clk(clk), .rst_n(rstN), .id_valid(in0.valid), .id_rs(in0.rs), .id_rt(in0.rt),
    .id_use_rs(in0.useRs), .id_use_rt(in0.useRt), .id_dest(in0.dest),
    .id_reg_write(in0.regWrite), .id_is_load(in0.isLoad), .id_is_ctrl(in0.isCtrl),
    .redirect(in0.redirect), .stall(stall0), .bubble(bubble0), .flush(flush0),
    .fwd_sel_rs(selRs0), .fwd_sel_rt(selRt0)
  );

  pipe_hazard_scoreboard #(
    .REG_AW(5), .DEPTH(3), .FWD_EN(0), .LOAD_LAT(2), .CTRL_MODE(1), .BR_STAGE(2)
  ) dutFlush (
    .clk(clk), .rst_n(rstN), .id_valid(in1.valid), .id_rs(in1.rs), .id_rt(in1.rt),
    .id_use_rs(in1.useRs), .id_use_rt(in1.useRt), .id_dest(in1.dest),
    .id_reg_write(in1.regWrite), .id_is_load(in1.isLoad), .id_is_ctrl(in1.isCtrl),
    .redirect(in1.redirect), .stall(stall1), .bubble(bubble1), .flush(flush1),
    .fwd_sel_rs(selRs1), .fwd_sel_rt(selRt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stimT nopS();
    stimT s;
    s = '0;
    s.rstN = 1'b1;
    return s;
  endfunction

  function automatic stimT op(input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt,
                              input logic useRs, input logic useRt, input logic we,
                              input logic ld, input logic ctrl);
    stimT s;
    s = nopS();
    s.valid = 1'b1; s.dest = dest; s.rs = rs; s.rt = rt;
    s.useRs = useRs; s.useRt = useRt; s.regWrite = we; s.isLoad = ld; s.isCtrl = ctrl;
    return s;
  endfunction

  function automatic stimT alu(input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt);
    return op(dest, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic stimT lw(input logic [4:0] dest, input logic [4:0] rs);
    return op(dest, rs, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic stimT br(input logic [4:0] rs, input logic [4:0] rt);
    return op(5'd0, rs, rt, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic stimT withRst(input stimT s);
    s.rstN = 1'b0;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // One ID cycle: drive, queue expectations, check comb outputs at negedge and
  // the registered selects just after the following rising edge.
  task automatic applyStimulus(input string name, input int which, input stimT s,
                               input logic eStall, input logic eBubble, input logic eFlush,
                               input logic [1:0] eRs, input logic [1:0] eRt);
    expT e;
    rstN = s.rstN;
    if (which == 0) begin in0 = s; in1 = nopS(); end
    else begin in1 = s; in0 = nopS(); end
    e.name = name; e.which = which; e.stall = eStall; e.bubble = eBubble;
    e.flush = eFlush; e.selRs = eRs; e.selRt = eRt;
    combQ.push_back(e);
    selQ.push_back(e);
    @(negedge clk);
    e = combQ.pop_front();
    checkOutput({e.name, ".stall"},  {7'd0, (e.which == 0) ? stall0  : stall1},  {7'd0, e.stall});
    checkOutput({e.name, ".bubble"}, {7'd0, (e.which == 0) ? bubble0 : bubble1}, {7'd0, e.bubble});
    checkOutput({e.name, ".flush"},  {7'd0, (e.which == 0) ? flush0  : flush1},  {7'd0, e.flush});
    @(posedge clk);
    #1;
    e = selQ.pop_front();
    checkOutput({e.name, ".selRs"}, {6'd0, (e.which == 0) ? selRs0 : selRs1}, {6'd0, e.selRs});
    checkOutput({e.name, ".selRt"}, {6'd0, (e.which == 0) ? selRt0 : selRt1}, {6'd0, e.selRt});
  endtask

  task automatic idleCycles(input int which, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus($sformatf("idle%0d_%0d", which, i), which, nopS(), 0, 0, 0, 2'd0, 2'd0);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stimT s;
    in0  = nopS();
    in1  = nopS();
    rstN = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("rst0", 0, withRst(alu(5'd3, 5'd1, 5'd2)), 0, 0, 0, 2'd0, 2'd0);
    applyStimulus("rst1", 1, withRst(alu(5'd3, 5'd1, 5'd2)), 0, 0, 0, 2'd0, 2'd0);

    // Forwarding distance, youngest-wins and unused-operand cases
    applyStimulus("A1", 0, alu(5'd3,  5'd1, 5'd2), 0, 0, 0, 2'd0, 2'd0);
    applyStimulus("A2", 0, alu(5'd4,  5'd3, 5'd5), 0, 0, 0, 2'd1, 2'd0);
    applyStimulus("A3", 0, alu(5'd8,  5'd3, 5'd4), 0, 0, 0, 2'd2, 2'd1);
    applyStimulus("A4", 0, alu(5'd9,  5'd3, 5'd0), 0, 0, 0, 2'd3, 2'd0);
    applyStimulus("A5", 0, alu(5'd10, 5'd3, 5'd9), 0, 0, 0, 2'd0, 2'd1);
    applyStimulus("A6", 0, alu(5'd3,  5'd1, 5'd2), 0, 0, 0, 2'd0, 2'd0);
    applyStimulus("A7", 0, alu(5'd3,  5'd3, 5'd1), 0, 0, 0, 2'd1, 2'd0);
    applyStimulus("A8", 0, alu(5'd11, 5'd3, 5'd3), 0, 0, 0, 2'd1, 2'd1);
    applyStimulus("A9", 0, op(5'd12, 5'd11, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 0, 0, 0, 2'd0, 2'd2);
    idleCycles(0, 3);

    // Load-use: one bubble, then forward from entry 1
    applyStimulus("B1", 0, lw(5'd3, 5'd1),         0, 0, 0, 2'd0, 2'd0);
    applyStimulus("B2", 0, alu(5'd4, 5'd3, 5'd3),  1, 1, 0, 2'd0, 2'd0);
    applyStimulus("B3", 0, alu(5'd4, 5'd3, 5'd3),  0, 0, 0, 2'd2, 2'd2);
    idleCycles(0, 3);

    // Branch in stall-until-resolve mode holds ID for BR_STAGE+1 cycles
    applyStimulus("C1", 0, br(5'd1, 5'd2),         0, 0, 0, 2'd0, 2'd0);
    applyStimulus("C2", 0, alu(5'd5, 5'd1, 5'd2),  1, 1, 0, 2'd0, 2'd0);
    applyStimulus("C3", 0, alu(5'd5, 5'd1, 5'd2),  1, 1, 0, 2'd0, 2'd0);
    applyStimulus("C4", 0, alu(5'd5, 5'd1, 5'd2),  1, 1, 0, 2'd0, 2'd0);
    applyStimulus("C5", 0, alu(5'd5, 5'd1, 5'd2),  0, 0, 0, 2'd0, 2'd0);
    idleCycles(0, 3);

    // Reset during CWAIT and during a pending load-use stall
    applyStimulus("D1", 0, br(5'd1, 5'd2),                  0, 0, 0, 2'd0, 2'd0);
    applyStimulus("D2", 0, alu(5'd6, 5'd1, 5'd2),           1, 1, 0, 2'd0, 2'd0);
    applyStimulus("D3", 0, withRst(alu(5'd6, 5'd1, 5'd2)),  0, 0, 0, 2'd0, 2'd0);
    applyStimulus("D4", 0, alu(5'd7, 5'd1, 5'd2),           0, 0, 0, 2'd0, 2'd0);
    applyStimulus("D5", 0, alu(5'd8, 5'd7, 5'd1),           0, 0, 0, 2'd1, 2'd0);
    applyStimulus("D6", 0, withRst(alu(5'd9, 5'd7, 5'd8)),  0, 0, 0, 2'd0, 2'd0);
    applyStimulus("D7", 0, alu(5'd9, 5'd7, 5'd8),           0, 0, 0, 2'd0, 2'd0);
    applyStimulus("E1", 0, lw(5'd3, 5'd1),                  0, 0, 0, 2'd0, 2'd0);
    applyStimulus("E2", 0, withRst(alu(5'd4, 5'd3, 5'd3)),  0, 0, 0, 2'd0, 2'd0);
    applyStimulus("E3", 0, alu(5'd4, 5'd3, 5'd3),           0, 0, 0, 2'd0, 2'd0);
    s = nopS();
    s.redirect = 1'b1;
    applyStimulus("R1", 0, s, 0, 0, 0, 2'd0, 2'd0);
    idleCycles(0, 2);

    // No forwarding: stall until the producer leaves WB; r0 never tracked
    applyStimulus("F1", 1, alu(5'd7, 5'd1, 5'd2),  0, 0, 0, 2'd0, 2'd0);
    applyStimulus("F2", 1, alu(5'd8, 5'd7, 5'd1),  1, 1, 0, 2'd0, 2'd0);
    applyStimulus("F3", 1, alu(5'd8, 5'd7, 5'd1),  1, 1, 0, 2'd0, 2'd0);
    applyStimulus("F4", 1, alu(5'd8, 5'd7, 5'd1),  1, 1, 0, 2'd0, 2'd0);
    applyStimulus("F5", 1, alu(5'd8, 5'd7, 5'd1),  0, 0, 0, 2'd0, 2'd0);
    applyStimulus("F6", 1, alu(5'd0, 5'd1, 5'd2),  0, 0, 0, 2'd0, 2'd0);
    applyStimulus("F7", 1, alu(5'd9, 5'd0, 5'd0),  0, 0, 0, 2'd0, 2'd0);
    idleCycles(1, 3);

    // Predict-not-taken: redirect kills the two younger writers
    applyStimulus("G1", 1, br(5'd1, 5'd2),         0, 0, 0, 2'd0, 2'd0);
    applyStimulus("G2", 1, alu(5'd5, 5'd1, 5'd2),  0, 0, 0, 2'd0, 2'd0);
    applyStimulus("G3", 1, alu(5'd6, 5'd1, 5'd2),  0, 0, 0, 2'd0, 2'd0);
    s = alu(5'd9, 5'd1, 5'd2);
    s.redirect = 1'b1;
    applyStimulus("G4", 1, s,                      0, 1, 1, 2'd0, 2'd0);
    applyStimulus("G5", 1, alu(5'd10, 5'd5, 5'd6), 0, 0, 0, 2'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
